// File: rtl/effects_chain_if.sv
// effects_chain_if: sample stream and per-sample effect parameters for the
// effects chain.
//   i_valid       sample strobe
//   i_sample      signed input sample
//   i_par_gain    overdrive gain, unsigned with fractional bits
//   ovrd_mode     0 = hard clip, 1 = soft clip
//   i_gate_thresh noise gate magnitude threshold
//   i_par_vol     output volume, Q1.7
//   i_bypass      bit0 overdrive, bit1 gate, bit2 volume
//   o_sample      signed output sample (holds while o_valid is low)
//   o_valid       output strobe
// master drives the sample stream; slave is the effects chain.
interface effects_chain_if #(
    parameter int fxp_size = 16
);
    logic                       i_valid;
    logic signed [fxp_size-1:0] i_sample;
    logic [10:0]                i_par_gain;
    logic                       ovrd_mode;
    logic [fxp_size-2:0]        i_gate_thresh;
    logic [7:0]                 i_par_vol;
    logic [2:0]                 i_bypass;
    logic signed [fxp_size-1:0] o_sample;
    logic                       o_valid;

    modport master (
        output i_valid, i_sample, i_par_gain, ovrd_mode, i_gate_thresh, i_par_vol, i_bypass,
        input  o_sample, o_valid
    );

    modport slave (
        input  i_valid, i_sample, i_par_gain, ovrd_mode, i_gate_thresh, i_par_vol, i_bypass,
        output o_sample, o_valid
    );
endinterface

// File: rtl/effects_chain.sv
// effects_chain: overdrive -> noise gate -> volume, fixed 3-cycle latency.
//   clk  single clock
//   rst  synchronous active-high reset
//   fx   effects_chain_if slave port (sample stream in, processed stream out)
// S1 captures the raw sample together with every parameter; the parameters
// then travel with the sample so a setting change never splits a sample.
// Overdrive sits between S1 and S2, the gate between S2 and S3, and volume
// between S3 and the output register.
module effects_chain #(
    parameter int fxp_size           = 16,
    parameter int bits_per_level     = 12,
    parameter int bits_per_gain_frac = 4,
    parameter int hold_samples       = 4
) (
    input  logic          clk,
    input  logic          rst,
    effects_chain_if.slave fx
);
    localparam int prod_w = fxp_size + 12;
    localparam int vol_w  = fxp_size + 9;
    localparam int cnt_w  = $clog2(hold_samples + 1);

    localparam logic signed [prod_w-1:0] knee_c     = prod_w'(32'sd1 <<< (bits_per_level - 2));
    localparam logic signed [prod_w-1:0] clip_max_c = prod_w'((32'sd1 <<< (bits_per_level - 1)) - 32'sd1);
    localparam logic signed [prod_w-1:0] clip_min_c = prod_w'(-(32'sd1 <<< (bits_per_level - 1)));
    localparam logic signed [vol_w-1:0]  vol_max_c  = vol_w'((32'sd1 <<< (fxp_size - 1)) - 32'sd1);
    localparam logic signed [vol_w-1:0]  vol_min_c  = vol_w'(-(32'sd1 <<< (fxp_size - 1)));
    localparam logic signed [fxp_size-1:0] smin_c   = {1'b1, {(fxp_size-1){1'b0}}};

    typedef enum logic [1:0] {
        GATE_OPEN   = 2'd0,
        GATE_HOLD   = 2'd1,
        GATE_CLOSED = 2'd2
    } gate_state_t;

    // pipeline registers
    logic                       s1_valid_r, s2_valid_r, s3_valid_r;
    logic signed [fxp_size-1:0] s1_sample_r, s2_sample_r, s3_sample_r;
    logic [10:0]                s1_gain_r;
    logic                       s1_mode_r;
    logic [fxp_size-2:0]        s1_thresh_r, s2_thresh_r;
    logic [7:0]                 s1_vol_r, s2_vol_r, s3_vol_r;
    logic [2:0]                 s1_bypass_r;
    logic [1:0]                 s2_bypass_r;   // [0] gate, [1] volume
    logic                       s3_bypass_r;   // volume
    logic signed [fxp_size-1:0] out_sample_r;
    logic                       out_valid_r;

    // gate FSM
    gate_state_t                gate_state_r, gate_next_s;
    logic [cnt_w-1:0]           gate_cnt_r, gate_cnt_next_s;

    // combinational stage results
    logic signed [prod_w-1:0]   od_a_s, od_b_s, od_prod_s, od_y_s, od_abs_s;
    logic signed [prod_w-1:0]   od_mag_s, od_soft_s, od_pre_s;
    logic signed [fxp_size-1:0] od_out_s;
    logic [fxp_size-2:0]        gate_abs_s;
    logic                       gate_below_s;
    logic signed [fxp_size-1:0] gate_out_s;
    logic signed [vol_w-1:0]    vol_a_s, vol_b_s, vol_prod_s, vol_y_s;
    logic signed [fxp_size-1:0] vol_out_s;

    // Overdrive: gain, optional soft knee compression, clamp to clip range.
    always_comb begin
        od_a_s    = {{12{s1_sample_r[fxp_size-1]}}, s1_sample_r};
        od_b_s    = {{(prod_w-11){1'b0}}, s1_gain_r};
        od_prod_s = od_a_s * od_b_s;
        od_y_s    = od_prod_s >>> bits_per_gain_frac;
        od_abs_s  = od_y_s[prod_w-1] ? -od_y_s : od_y_s;
        od_mag_s  = knee_c + ((od_abs_s - knee_c) >>> 2'd2);
        if (od_abs_s > knee_c) begin
            od_soft_s = od_y_s[prod_w-1] ? -od_mag_s : od_mag_s;
        end else begin
            od_soft_s = od_y_s;
        end
        od_pre_s = s1_mode_r ? od_soft_s : od_y_s;
        if (s1_bypass_r[0]) begin
            od_out_s = s1_sample_r;
        end else if (od_pre_s > clip_max_c) begin
            od_out_s = clip_max_c[fxp_size-1:0];
        end else if (od_pre_s < clip_min_c) begin
            od_out_s = clip_min_c[fxp_size-1:0];
        end else begin
            od_out_s = od_pre_s[fxp_size-1:0];
        end
    end

    // Gate magnitude: the most negative code saturates instead of wrapping.
    always_comb begin
        if (s2_sample_r == smin_c) begin
            gate_abs_s = {(fxp_size-1){1'b1}};
        end else if (s2_sample_r[fxp_size-1]) begin
            gate_abs_s = ~s2_sample_r[fxp_size-2:0] + {{(fxp_size-2){1'b0}}, 1'b1};
        end else begin
            gate_abs_s = s2_sample_r[fxp_size-2:0];
        end
        gate_below_s = (gate_abs_s < s2_thresh_r);
    end

    // Gate next-state and output; the FSM only moves on valid samples.
    always_comb begin
        gate_next_s     = gate_state_r;
        gate_cnt_next_s = gate_cnt_r;
        gate_out_s      = s2_sample_r;
        if (!s2_valid_r) begin
            gate_next_s     = gate_state_r;
        end else if (s2_bypass_r[0]) begin
            gate_next_s     = GATE_OPEN;
            gate_cnt_next_s = {cnt_w{1'b0}};
        end else begin
            case (gate_state_r)
                GATE_OPEN: begin
                    if (gate_below_s) begin
                        gate_next_s     = GATE_HOLD;
                        gate_cnt_next_s = cnt_w'(1'b1);
                    end else begin
                        gate_next_s     = GATE_OPEN;
                    end
                end
                GATE_HOLD: begin
                    if (!gate_below_s) begin
                        gate_next_s     = GATE_OPEN;
                        gate_cnt_next_s = {cnt_w{1'b0}};
                    end else if (gate_cnt_r == cnt_w'(hold_samples)) begin
                        gate_next_s     = GATE_CLOSED;
                        gate_out_s      = {fxp_size{1'b0}};
                    end else begin
                        gate_cnt_next_s = gate_cnt_r + cnt_w'(1'b1);
                    end
                end
                GATE_CLOSED: begin
                    if (!gate_below_s) begin
                        gate_next_s     = GATE_OPEN;
                        gate_cnt_next_s = {cnt_w{1'b0}};
                    end else begin
                        gate_out_s      = {fxp_size{1'b0}};
                    end
                end
                default: begin
                    gate_next_s     = GATE_OPEN;
                    gate_cnt_next_s = {cnt_w{1'b0}};
                end
            endcase
        end
    end

    // Volume: Q1.7 scale with saturation to the sample range.
    always_comb begin
        vol_a_s    = {{9{s3_sample_r[fxp_size-1]}}, s3_sample_r};
        vol_b_s    = {{(vol_w-8){1'b0}}, s3_vol_r};
        vol_prod_s = vol_a_s * vol_b_s;
        vol_y_s    = vol_prod_s >>> 3'd7;
        if (s3_bypass_r) begin
            vol_out_s = s3_sample_r;
        end else if (vol_y_s > vol_max_c) begin
            vol_out_s = vol_max_c[fxp_size-1:0];
        end else if (vol_y_s < vol_min_c) begin
            vol_out_s = vol_min_c[fxp_size-1:0];
        end else begin
            vol_out_s = vol_y_s[fxp_size-1:0];
        end
    end

    // Gate FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_state_r <= GATE_OPEN;
            gate_cnt_r   <= {cnt_w{1'b0}};
        end else begin
            gate_state_r <= gate_next_s;
            gate_cnt_r   <= gate_cnt_next_s;
        end
    end

    // Pipeline slots; S1 captures parameters only alongside a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_sample_r  <= {fxp_size{1'b0}};
            s1_gain_r    <= 11'd1 << bits_per_gain_frac;
            s1_mode_r    <= 1'b0;
            s1_thresh_r  <= {(fxp_size-1){1'b0}};
            s1_vol_r     <= 8'd128;
            s1_bypass_r  <= 3'd0;
            s2_valid_r   <= 1'b0;
            s2_sample_r  <= {fxp_size{1'b0}};
            s2_thresh_r  <= {(fxp_size-1){1'b0}};
            s2_vol_r     <= 8'd128;
            s2_bypass_r  <= 2'd0;
            s3_valid_r   <= 1'b0;
            s3_sample_r  <= {fxp_size{1'b0}};
            s3_vol_r     <= 8'd128;
            s3_bypass_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_sample_r <= {fxp_size{1'b0}};
        end else begin
            s1_valid_r <= fx.i_valid;
            if (fx.i_valid) begin
                s1_sample_r <= fx.i_sample;
                s1_gain_r   <= fx.i_par_gain;
                s1_mode_r   <= fx.ovrd_mode;
                s1_thresh_r <= fx.i_gate_thresh;
                s1_vol_r    <= fx.i_par_vol;
                s1_bypass_r <= fx.i_bypass;
            end else begin
                s1_sample_r <= s1_sample_r;
            end
            s2_valid_r  <= s1_valid_r;
            s2_sample_r <= od_out_s;
            s2_thresh_r <= s1_thresh_r;
            s2_vol_r    <= s1_vol_r;
            s2_bypass_r <= s1_bypass_r[2:1];
            s3_valid_r  <= s2_valid_r;
            s3_sample_r <= gate_out_s;
            s3_vol_r    <= s2_vol_r;
            s3_bypass_r <= s2_bypass_r[1];
            out_valid_r <= s3_valid_r;
            // output sample holds between valid strobes
            if (s3_valid_r) begin
                out_sample_r <= vol_out_s;
            end else begin
                out_sample_r <= out_sample_r;
            end
        end
    end

    assign fx.o_sample = out_sample_r;
    assign fx.o_valid  = out_valid_r;
endmodule

// File: tb/tb_effects_chain.sv
// tb_effects_chain: directed vectors with hand-computed expectations for
// effects_chain (fxp_size 16, bits_per_level 12, gain_frac 4, hold 4).
module tb_effects_chain;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    effects_chain_if #(.fxp_size(16)) fx_if ();

    effects_chain #(
        .fxp_size(16),
        .bits_per_level(12),
        .bits_per_gain_frac(4),
        .hold_samples(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fx (fx_if)
    );

    int total = 0;
    int bad   = 0;

    int         s_q[$];
    int         g_q[$];
    int         e_q[$];
    logic       mode_v;
    int         thresh_v;
    int         vol_v;
    logic [2:0] byp_v;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int s, input int g);
        fx_if.i_valid       = v;
        fx_if.i_sample      = 16'(s);
        fx_if.i_par_gain    = 11'(g);
        fx_if.ovrd_mode     = mode_v;
        fx_if.i_gate_thresh = 15'(thresh_v);
        fx_if.i_par_vol     = 8'(vol_v);
        fx_if.i_bypass      = byp_v;
    endtask

    // Sample j is captured at edge j and must appear after edge j+3.
    task automatic run_stream(input string name);
        int n;
        n = s_q.size();
        for (int t = 0; t < n + 4; t++) begin
            if (t < n) drive(1'b1, s_q[t], g_q[t]);
            else       drive(1'b0, 0, 16);
            @(posedge clk);
            @(negedge clk);
            if (t >= 3 && t - 3 < n) begin
                check_eq($sformatf("%s_valid%0d", name, t - 3), int'(fx_if.o_valid), 1);
                check_eq($sformatf("%s_sample%0d", name, t - 3), int'(fx_if.o_sample), e_q[t - 3]);
            end else begin
                check_eq($sformatf("%s_idle%0d", name, t), int'(fx_if.o_valid), 0);
            end
        end
        check_eq($sformatf("%s_hold", name), int'(fx_if.o_sample), e_q[n - 1]);
    endtask

    initial begin
        mode_v   = 1'b0;
        thresh_v = 0;
        vol_v    = 128;
        byp_v    = 3'b000;
        rst      = 1'b1;
        drive(1'b1, 123, 16);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", int'(fx_if.o_valid), 0);
        check_eq("rst_sample", int'(fx_if.o_sample), 0);
        rst = 1'b0;
        drive(1'b0, 0, 16);

        s_q = '{100};       g_q = '{16};       e_q = '{100};
        run_stream("pass");

        s_q = '{1000, -1000}; g_q = '{160, 160}; e_q = '{2047, -2048};
        run_stream("hard");

        mode_v = 1'b1;
        s_q = '{1500, 3000, 500}; g_q = '{16, 16, 16}; e_q = '{1143, 1518, 500};
        run_stream("soft");
        mode_v = 1'b0;

        thresh_v = 50;
        s_q = '{200, 10, 10, 10, 10, 10, 60};
        g_q = '{16, 16, 16, 16, 16, 16, 16};
        e_q = '{200, 10, 10, 10, 10, 0, 60};
        run_stream("gate");
        byp_v = 3'b010;
        e_q = '{200, 10, 10, 10, 10, 10, 60};
        run_stream("gate_byp");
        byp_v    = 3'b000;
        thresh_v = 0;

        byp_v = 3'b001;
        vol_v = 255;
        s_q = '{20000, -20000, 64}; g_q = '{16, 16, 16}; e_q = '{32767, -32768, 127};
        run_stream("vol");
        byp_v = 3'b101;
        e_q = '{20000, -20000, 64};
        run_stream("vol_byp");
        byp_v = 3'b000;
        vol_v = 128;

        s_q = '{100, 100}; g_q = '{16, 32}; e_q = '{100, 200};
        run_stream("atomic");

        // three samples in flight, then a one-cycle reset with a dropped sample
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 300 + k, 16);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        drive(1'b1, 999, 16);
        @(posedge clk);
        @(negedge clk);
        check_eq("mrst_valid", int'(fx_if.o_valid), 0);
        check_eq("mrst_sample", int'(fx_if.o_sample), 0);
        rst = 1'b0;
        drive(1'b0, 0, 16);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("mrst_quiet%0d", k), int'(fx_if.o_valid), 0);
        end
        s_q = '{77}; g_q = '{16}; e_q = '{77};
        run_stream("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/effects_chain.md
# effects_chain

Parametrised three-stage guitar effects chain: input gain with hard/soft clipping overdrive, a noise gate with hold timer, and output volume with saturation. It replaces the single-overdrive pipeline between the ADC sample deserialiser and the DAC serialiser. Each stage has a bypass. The `i_valid` strobe propagates with fixed latency, so `o_valid` marks real output samples. Parameters are captured with each sample and travel with it, so no sample ever sees a mix of old and new settings.

## Interface
- `fxp_size`, 16, signed sample width (two's complement).
- `bits_per_level`, 12, clip ceiling exponent; clip range is [-2^(bits_per_level-1), 2^(bits_per_level-1)-1].
- `bits_per_gain_frac`, 4, fractional bits of `i_par_gain`.
- `hold_samples`, 4, number of consecutive below-threshold samples passed before the gate closes (≥1).
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  sample strobe; any duty cycle, back-to-back allowed.
- `i_sample`  in  fxp_size  signed input sample.
- `i_par_gain`  in  11  unsigned gain, `bits_per_gain_frac` fractional bits.
- `ovrd_mode`  in  1  0 = hard clip, 1 = soft clip.
- `i_gate_thresh`  in  fxp_size-1  unsigned magnitude threshold.
- `i_par_vol`  in  8  unsigned volume, Q1.7 (128 = 1.0).
- `i_bypass`  in  3  bit0 = overdrive, bit1 = gate, bit2 = volume.
- `o_sample`  out  fxp_size  signed output sample.
- `o_valid`  out  1  output strobe.

## Operation
- Pipeline slots S1 (overdrive), S2 (gate) and S3 (volume) each register one sample plus its valid bit. Every slot loads every cycle; a slot with valid = 0 holds don't-care data.
- Parameter capture: on a cycle with `i_valid` = 1, S1 latches `i_sample`, gain, mode, threshold, volume and bypass. Threshold, volume and the remaining bypass bits move forward with the sample into S2 and S3. Parameter inputs on cycles with `i_valid` = 0 are ignored.
- Overdrive (S1 input):
  - Compute p = i_sample × gain as a signed product of fxp_size+12 bits.
  - Compute y = p >>> bits_per_gain_frac (arithmetic shift).
  - Knee k = 2^(bits_per_level-2).
  - Hard mode: clamp y to the clip range.
  - Soft mode: if |y| > k, the magnitude becomes k + ((|y|-k) >> 2) with the sign restored. Then clamp to the clip range.
  - Bypass bit0: the input passes unchanged.
- Noise gate (S2 input, sample x):
  - States OPEN, HOLD, CLOSED, plus a hold counter cnt. The FSM advances only on valid samples.
  - "below" means |x| < thresh. |−2^(fxp_size-1)| saturates to 2^(fxp_size-1)-1.
  - OPEN: pass x. If below, go to HOLD with cnt = 1.
  - HOLD: pass x. If not below, go to OPEN. Else if cnt == hold_samples, go to CLOSED and output 0 for this sample. Else cnt++.
  - CLOSED: output 0. If not below, go to OPEN and pass this sample.
  - Bypass bit1: pass x and force the state to OPEN with cnt = 0.
  - thresh = 0 never closes the gate.
- Volume (S3 input): v = (x × vol) >>> 7, saturated to the signed fxp_size range. Bypass bit2 passes x unchanged.
- Bypass never changes latency.

## Timing
- Latency is fixed at 3 cycles. A sample with `i_valid` = 1 at edge n appears on `o_sample` with `o_valid` = 1 after edge n+3.
- `o_valid` is exactly `i_valid` delayed by 3 cycles. `o_sample` holds its value while `o_valid` = 0.
- Throughput is one sample per cycle.
- Reset (on any edge with `rst` = 1, including mid-stream):
  - All valid bits clear, so `o_valid` = 0 from the next cycle.
  - `o_sample` = 0.
  - Gate state = OPEN, cnt = 0.
  - Pipeline parameter registers: gain = 1 << bits_per_gain_frac, mode 0, thresh 0, vol 128, bypass 0.
  - In-flight samples are discarded. Samples arriving with `i_valid` = 1 while `rst` = 1 are dropped.
- Simultaneous parameter change and `i_valid`: the sample on that edge uses the new values.

## Test plan
Parameters: fxp_size 16, bits_per_level 12, gain_frac 4, hold_samples 4. Defaults unless stated: gain 16, vol 128, bypass 0, thresh 0.
- Pass-through: reset, then `i_sample` = 100 with `i_valid` for 1 cycle → `o_sample` = 100 and `o_valid` high for exactly one cycle, 3 cycles later. Outputs are 0 during reset.
- Hard clip: gain 160, samples 1000 then −1000 back-to-back → outputs 2047, −2048 on consecutive cycles.
- Soft clip: mode 1, samples 1500, 3000, 500 → outputs 1143, 1518, 500.
- Gate: thresh 50, samples 200, 10, 10, 10, 10, 10, 60 → outputs 200, 10, 10, 10, 10, 0, 60. With bit1 bypass set on the same stream → all pass unchanged.
- Volume saturation and bypass: bypass bit0 set, vol 255, samples 20000, −20000, 64 → outputs 32767, −32768, 127. With bit2 also set → 20000, −20000, 64.
- Parameter atomicity and reset:
  - Back-to-back samples 100, 100 with gain changed from 16 to 32 between them → outputs 100, 200. Check that the gain change applies only to the second sample.
  - Assert `rst` for 1 cycle while 3 samples are in flight → no `o_valid` afterwards until new input, and the next sample still has latency 3.
